// File: rtl/key_beep_pkg.sv
// -----------------------------------------------------------------------------
// key_beep_pkg
//   Shared definitions for the push-button beeper:
//   - key polarity constants (the board key is active-low)
//   - default cycle counts for a 50 MHz system clock
//   - counter width helper for the optional tone generator
//   No ports; imported by key_debounce and key_beep_ctrl.
// -----------------------------------------------------------------------------
package key_beep_pkg;

    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    // 20 ms of stable key level at 50 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES  = 1_000_000;
    // 1 kHz tone at 50 MHz (half-period in cycles).
    localparam int DEFAULT_BEEP_HALF_PERIOD = 25_000;

    // Width of a down-counter holding 0 .. n-1; at least one bit so that a
    // half-period of 1 still yields a legal vector.
    function automatic int tone_cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Two-flop synchroniser followed by a stability counter for one active-low
//   mechanical key. A new key level is accepted only once the synchronised
//   input has differed from the accepted level for DEBOUNCE_CYCLES
//   consecutive edges; any return to the old level restarts the count.
//
// Ports
//   sys_clk      in   system clock, rising edge
//   sys_rst      in   synchronous active-high reset
//   key_in       in   raw asynchronous key, 0 = pressed
//   key_state    out  accepted (debounced) key level, 1 = released
//   press_pulse  out  high for the one cycle whose closing edge moves
//                     key_state from released to pressed
// -----------------------------------------------------------------------------
module key_debounce
    import key_beep_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_state,
    output logic press_pulse
);

    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // The count has run its full length and the input still disagrees with
    // the accepted level: the next edge takes the new level.
    assign accept = (s2 != key_state) && (cnt == CNT_MAX);

    // Combinational so that the consumer acts on the same edge that updates
    // key_state; s2 and key_state are both flops, so there is still no path
    // from the raw pin.
    assign press_pulse = accept && (s2 == KEY_PRESSED);

    // NOTE: every flop here is updated with <= so all right-hand sides read
    // the pre-edge values; with = the s1 -> s2 chain would collapse into one
    // stage and the counter would compare against an already-updated state.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1        <= KEY_RELEASED;
            s2        <= KEY_RELEASED;
            key_state <= KEY_RELEASED;
            cnt       <= '0;
        end else begin
            s1 <= key_in;
            s2 <= s1;
            if (s2 == key_state) begin
                cnt <= '0;
            end else if (accept) begin
                key_state <= s2;
                cnt       <= '0;
            end else begin
                // Cannot wrap: accept fires and clears the count at CNT_MAX.
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_beep_ctrl.sv
// -----------------------------------------------------------------------------
// key_beep_ctrl
//   Push-button beeper. Each debounced press of the key toggles the buzzer
//   on or off; releases are ignored and holding the key does not repeat.
//
//   Build option KEY_BEEP_PWM_EN:
//     defined   - beep is a square wave of half-period BEEP_HALF_PERIOD while
//                 the buzzer is on (passive buzzer), starting high on the
//                 edge after it is switched on
//     undefined - beep follows the on/off flop directly (active buzzer)
//
// Ports
//   sys_clk   in   system clock, rising edge
//   sys_rst   in   synchronous active-high reset
//   key       in   raw asynchronous key, 0 = pressed
//   beep      out  registered buzzer drive, 1 = sounding
// -----------------------------------------------------------------------------
module key_beep_ctrl
    import key_beep_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
    parameter int BEEP_HALF_PERIOD = DEFAULT_BEEP_HALF_PERIOD
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key,
    output logic beep
);

    logic key_state;
    logic press_pulse;
    logic beep_on;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key_in      (key),
        .key_state   (key_state),
        .press_pulse (press_pulse)
    );

    // press_pulse only fires while the accepted level is still "released";
    // qualifying with key_state ties the toggle to a genuine 1->0 move.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            beep_on <= 1'b0;
        end else if (press_pulse && (key_state == KEY_RELEASED)) begin
            beep_on <= ~beep_on;
        end
    end

`ifdef KEY_BEEP_PWM_EN
    localparam int              TONE_W   = tone_cnt_width(BEEP_HALF_PERIOD);
    localparam logic [TONE_W-1:0] TONE_MAX = TONE_W'(BEEP_HALF_PERIOD - 1);

    logic [TONE_W-1:0] tone_cnt;

    // tone_cnt counts down the remaining cycles of the current half-period;
    // reaching 0 flips beep and reloads. Holding it at 0 while off makes the
    // first edge after switch-on drive beep high.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tone_cnt <= '0;
            beep     <= 1'b0;
        end else if (!beep_on) begin
            tone_cnt <= '0;
            beep     <= 1'b0;
        end else if (tone_cnt == '0) begin
            tone_cnt <= TONE_MAX;
            beep     <= ~beep;
        end else begin
            tone_cnt <= tone_cnt - 1'b1;
        end
    end
`else
    // beep_on is a flop, so the output stays registered.
    assign beep = beep_on;
`endif

endmodule

// File: tb/tb_key_beep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_beep_ctrl
//   Directed bench for key_beep_ctrl with DEBOUNCE_CYCLES=5,
//   BEEP_HALF_PERIOD=3 and a 20 ns clock. Inputs change and outputs are
//   sampled on the falling edge; "edge i" below is the i-th rising edge
//   after a stimulus change. With a 5-cycle debounce a press held from
//   edge 1 toggles the buzzer at edge 7.
// -----------------------------------------------------------------------------
module tb_key_beep_ctrl;

    localparam int DEB  = 5;
    localparam int HALF = 3;

    logic clk;
    logic sys_rst;
    logic key;
    logic beep;
    logic level;

    int checks = 0;
    int errors = 0;
    logic exp_level = 1'b0;

    key_beep_ctrl #(
        .DEBOUNCE_CYCLES  (DEB),
        .BEEP_HALF_PERIOD (HALF)
    ) dut (
        .sys_clk (clk),
        .sys_rst (sys_rst),
        .key     (key),
        .beep    (beep)
    );

    // On/off level of the buzzer; in the tone build the pin itself is a
    // square wave, so the on/off flop is observed instead.
`ifdef KEY_BEEP_PWM_EN
    assign level = dut.beep_on;
`else
    assign level = beep;
`endif

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        sys_rst = 1'b1;
        key     = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        checks++;
        if (beep !== 1'b0) begin
            errors++;
            $display("FAIL reset_beep: got %b expected 0", beep);
        end
        checks++;
        if (dut.u_debounce.key_state !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got %b expected 1", dut.u_debounce.key_state);
        end
        checks++;
        if (dut.u_debounce.cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", dut.u_debounce.cnt);
        end
        tick(3);
        checks++;
        if (level !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 0", level);
        end
        exp_level = 1'b0;
    endtask

    // Clean press held 10 cycles: toggle at edge 7, nothing after.
    task automatic test_clean_press;
        logic old_level;
        logic want;
        old_level = exp_level;
        key = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            want = (i >= 7) ? ~old_level : old_level;
            checks++;
            if (level !== want) begin
                errors++;
                $display("FAIL clean_press edge %0d: got %b expected %b", i, level, want);
            end
        end
        exp_level = ~old_level;
        key = 1'b1;
        tick(10);
        checks++;
        if (level !== exp_level) begin
            errors++;
            $display("FAIL clean_release: got %b expected %b", level, exp_level);
        end
        checks++;
        if (dut.u_debounce.key_state !== 1'b1) begin
            errors++;
            $display("FAIL clean_release_state: got %b expected 1", dut.u_debounce.key_state);
        end
    endtask

    // 0,1,0,1 bounce then 9 low: low starts at edge 5, so toggle at edge 11.
    task automatic test_bouncy_press;
        logic old_level;
        logic want;
        old_level = exp_level;
        for (int i = 1; i <= 13; i++) begin
            key = (i <= 4) ? ((i % 2) == 0) : 1'b0;
            tick(1);
            want = (i >= 11) ? ~old_level : old_level;
            checks++;
            if (level !== want) begin
                errors++;
                $display("FAIL bouncy_press edge %0d: got %b expected %b", i, level, want);
            end
        end
        exp_level = ~old_level;
    endtask

    // 1,0,1,0 bounce then 9 high: release accepted, buzzer untouched.
    task automatic test_bouncy_release;
        for (int i = 1; i <= 13; i++) begin
            key = (i <= 4) ? ((i % 2) == 1) : 1'b1;
            tick(1);
            checks++;
            if (level !== exp_level) begin
                errors++;
                $display("FAIL bouncy_release edge %0d: got %b expected %b", i, level, exp_level);
            end
        end
        checks++;
        if (dut.u_debounce.key_state !== 1'b1) begin
            errors++;
            $display("FAIL bouncy_release_state: got %b expected 1", dut.u_debounce.key_state);
        end
    endtask

    task automatic test_release_repress;
        test_bouncy_release();
        test_bouncy_press();
        key = 1'b1;
        tick(10);
    endtask

    // Four low cycles are one short of the debounce length: rejected.
    task automatic test_short_glitch;
        for (int i = 1; i <= 14; i++) begin
            key = (i <= 4) ? 1'b0 : 1'b1;
            tick(1);
            checks++;
            if (level !== exp_level) begin
                errors++;
                $display("FAIL short_glitch edge %0d: got %b expected %b", i, level, exp_level);
            end
        end
        checks++;
        if (dut.u_debounce.key_state !== 1'b1) begin
            errors++;
            $display("FAIL short_glitch_state: got %b expected 1", dut.u_debounce.key_state);
        end
    endtask

    // Exactly five low cycles: accepted at edge 7, release at edge 12.
    task automatic test_exact_min;
        logic old_level;
        logic want;
        old_level = exp_level;
        for (int i = 1; i <= 16; i++) begin
            key = (i <= 5) ? 1'b0 : 1'b1;
            tick(1);
            want = (i >= 7) ? ~old_level : old_level;
            checks++;
            if (level !== want) begin
                errors++;
                $display("FAIL exact_min edge %0d: got %b expected %b", i, level, want);
            end
        end
        exp_level = ~old_level;
        checks++;
        if (dut.u_debounce.key_state !== 1'b1) begin
            errors++;
            $display("FAIL exact_min_release: got %b expected 1", dut.u_debounce.key_state);
        end
    endtask

    // Press, reset after the third count step, release during reset.
    task automatic test_reset_mid_count;
        key = 1'b0;
        tick(5);
        checks++;
        if (dut.u_debounce.cnt !== 3'd3) begin
            errors++;
            $display("FAIL mid_count_cnt: got %0d expected 3", dut.u_debounce.cnt);
        end
        sys_rst = 1'b1;
        key     = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        exp_level = 1'b0;
        checks++;
        if (dut.u_debounce.cnt !== 3'd0) begin
            errors++;
            $display("FAIL mid_count_cleared: got %0d expected 0", dut.u_debounce.cnt);
        end
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            checks++;
            if (beep !== 1'b0) begin
                errors++;
                $display("FAIL mid_count_beep edge %0d: got %b expected 0", i, beep);
            end
        end
        checks++;
        if (dut.u_debounce.key_state !== 1'b1) begin
            errors++;
            $display("FAIL mid_count_state: got %b expected 1", dut.u_debounce.key_state);
        end
    endtask

`ifdef KEY_BEEP_PWM_EN
    // beep_on rises at edge 7; beep: 0 at edge 7, then 111000 repeating.
    task automatic test_pwm;
        logic want;
        key = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            tick(1);
            want = (i < 8) ? 1'b0 : ((((i - 8) / HALF) % 2) == 0);
            checks++;
            if (beep !== want) begin
                errors++;
                $display("FAIL pwm_on edge %0d: got %b expected %b", i, beep, want);
            end
        end
        key = 1'b1;
        tick(12);
        // Second press switches off at edge 7; beep low from edge 8.
        key = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (i >= 8) begin
                checks++;
                if (beep !== 1'b0) begin
                    errors++;
                    $display("FAIL pwm_off edge %0d: got %b expected 0", i, beep);
                end
            end
        end
        checks++;
        if (dut.tone_cnt !== '0) begin
            errors++;
            $display("FAIL pwm_tone_cnt: got %0d expected 0", dut.tone_cnt);
        end
        key = 1'b1;
        tick(12);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b1;
        key     = 1'b1;
        test_reset();
        test_clean_press();
        test_bouncy_press();
        test_release_repress();
        test_short_glitch();
        test_exact_min();
        test_reset_mid_count();
`ifdef KEY_BEEP_PWM_EN
        test_pwm();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
